// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default: data priority).
package unified_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/unified_mem_arb_pick.sv
// Combinational winner selection between the fetch and data ports.
// ARB_RR_EN: round-robin on conflict; otherwise data always beats fetch.
module unified_mem_arb_pick
  import unified_mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic i_cancel_i,
`ifdef ARB_RR_EN
  input  gnt_e last_gnt_i,
`endif
  output logic valid_o,
  output gnt_e gnt_o
);

  logic i_ok;

  // A fetch being cancelled in the same cycle is not eligible
  assign i_ok    = i_req_i & ~i_cancel_i;
  assign valid_o = i_ok | d_req_i;

  // Pick the winner; only meaningful when valid_o is high
  always_comb begin
    gnt_o = GNT_I;
`ifdef ARB_RR_EN
    if (d_req_i && (!i_ok || (last_gnt_i == GNT_I))) gnt_o = GNT_D;
`else
    if (d_req_i) gnt_o = GNT_D;
`endif
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between IF and MEM stages.
// Optional feature: define ARB_RR_EN for round-robin arbitration (default: data priority).
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, pick_gnt;
  logic              pick_valid;
  logic [CNT_W-1:0]  cnt_q;
  logic              cancel_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
`ifdef ARB_RR_EN
  gnt_e              last_q;
`endif

  unified_mem_arb_pick u_pick (
    .i_req_i    (i_req),
    .d_req_i    (d_req),
    .i_cancel_i (i_cancel),
`ifdef ARB_RR_EN
    .last_gnt_i (last_q),
`endif
    .valid_o    (pick_valid),
    .gnt_o      (pick_gnt)
  );

  // State register
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one grant, MEM_LAT busy cycles, one response cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = BUSY;
      BUSY:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter, cancel flag and read-data capture
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      gnt_q     <= GNT_I;
      cnt_q     <= '0;
      cancel_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q    <= pick_gnt;
            cnt_q    <= CntInit;
            cancel_q <= 1'b0;
            addr_q   <= (pick_gnt == GNT_D) ? d_addr : i_addr;
            we_q     <= (pick_gnt == GNT_D) && d_we;
            wdata_q  <= d_wdata;
          end
        end
        BUSY: begin
          // The access itself always completes; only the ack is dropped
          if ((gnt_q == GNT_I) && i_cancel) cancel_q <= 1'b1;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (gnt_q == GNT_I) begin
            i_rdata_q <= mem_rdata;
          end else if (!we_q) begin
            // Stores leave the previous load data untouched
            d_rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Remember the most recent winner for round-robin
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn)                                last_q <= GNT_I;
    else if ((state_q == IDLE) && pick_valid) last_q <= pick_gnt;
  end
`endif

  // Outputs decoded from registered state only (acks also honour a late fetch cancel)
  always_comb begin
    mem_en    = (state_q == BUSY);
    mem_we    = (state_q == BUSY) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ack     = (state_q == RESP) && (gnt_q == GNT_I) && !cancel_q && !i_cancel;
    d_ack     = (state_q == RESP) && (gnt_q == GNT_D);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: four arbiters (MEM_LAT 2, 4, 1, 15) share one stimulus stream and
// each is compared every cycle against a transaction-level timing model.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  localparam int NI = 4;

  function automatic int lat_of(input int n);
    case (n)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  // Memory content is a fixed function of the address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a ^ 32'h2002_0045;
  endfunction

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic        i_req = 1'b0, i_cancel = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;

  logic [NI-1:0] i_ack_w, d_ack_w, mem_en_w, mem_we_w;
  logic [31:0]   i_rdata_w [NI];
  logic [31:0]   d_rdata_w [NI];
  logic [31:0]   mem_addr_w [NI];
  logic [31:0]   mem_wdata_w [NI];
  logic [31:0]   mem_rdata_w [NI];
  int            en_run [NI];

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    unified_mem_arbiter #(
      .MEM_LAT (lat_of(g)),
      .ADDR_W  (32),
      .DATA_W  (32)
    ) u_dut (
      .Clk       (Clk),
      .Clrn      (Clrn),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_cancel  (i_cancel),
      .i_ack     (i_ack_w[g]),
      .i_rdata   (i_rdata_w[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack_w[g]),
      .d_rdata   (d_rdata_w[g]),
      .mem_en    (mem_en_w[g]),
      .mem_we    (mem_we_w[g]),
      .mem_addr  (mem_addr_w[g]),
      .mem_wdata (mem_wdata_w[g]),
      .mem_rdata (mem_rdata_w[g])
    );
  end

  // Memory: data is only valid in the last enabled cycle, garbage before that
  always @(posedge Clk or negedge Clrn) begin
    for (int n = 0; n < NI; n++)
      en_run[n] <= (!Clrn || !mem_en_w[n]) ? 0 : en_run[n] + 1;
  end

  always_comb begin
    for (int n = 0; n < NI; n++)
      mem_rdata_w[n] = (mem_en_w[n] && (en_run[n] == lat_of(n) - 1)) ?
                       mem_val(mem_addr_w[n]) : (32'hBAD0_0000 | 32'(en_run[n]));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // Per instance: an active service with a position 1..L (memory busy) or L+1 (response).
  bit          m_act   [NI];
  int          m_pos   [NI];
  bit          m_port  [NI];   // 1 = data
  bit          m_we    [NI];
  bit          m_canc  [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_dlast [NI];
`ifdef ARB_RR_EN
  bit          m_last  [NI];   // 1 = data granted last
`endif

  always @(posedge Clk or negedge Clrn) begin
    for (int n = 0; n < NI; n++) begin
      bit iok, dwin;
      iok = i_req && !i_cancel;
`ifdef ARB_RR_EN
      dwin = d_req && (!iok || !m_last[n]);
`else
      dwin = d_req;
`endif
      if (!Clrn) begin
        m_act[n]   <= 1'b0;
        m_dlast[n] <= '0;
`ifdef ARB_RR_EN
        m_last[n]  <= 1'b0;
`endif
      end else if (!m_act[n]) begin
        if (iok || d_req) begin
          m_act[n]   <= 1'b1;
          m_pos[n]   <= 1;
          m_canc[n]  <= 1'b0;
          m_port[n]  <= dwin;
          m_we[n]    <= dwin && d_we;
          m_addr[n]  <= dwin ? d_addr : i_addr;
          m_wdata[n] <= d_wdata;
`ifdef ARB_RR_EN
          m_last[n]  <= dwin;
`endif
        end
      end else begin
        if (m_pos[n] <= lat_of(n) && !m_port[n] && i_cancel) m_canc[n] <= 1'b1;
        if (m_pos[n] == lat_of(n) + 1) begin
          m_act[n] <= 1'b0;
          if (m_port[n] && !m_we[n]) m_dlast[n] <= mem_val(m_addr[n]);
        end else begin
          m_pos[n] <= m_pos[n] + 1;
        end
      end
    end
  end

  // Compare every instance against the model mid-cycle
  always @(negedge Clk) begin
    for (int n = 0; n < NI; n++) begin
      bit busy, resp, exp_i, exp_d;
      if (!Clrn) begin
        check($sformatf("rst_mem_en[%0d]", n), 32'(mem_en_w[n]), 32'd0);
        check($sformatf("rst_mem_we[%0d]", n), 32'(mem_we_w[n]), 32'd0);
        check($sformatf("rst_i_ack[%0d]", n), 32'(i_ack_w[n]), 32'd0);
        check($sformatf("rst_d_ack[%0d]", n), 32'(d_ack_w[n]), 32'd0);
      end else begin
        busy  = m_act[n] && (m_pos[n] <= lat_of(n));
        resp  = m_act[n] && (m_pos[n] == lat_of(n) + 1);
        exp_i = resp && !m_port[n] && !m_canc[n] && !i_cancel;
        exp_d = resp && m_port[n];
        check($sformatf("mem_en[%0d]", n), 32'(mem_en_w[n]), 32'(busy));
        check($sformatf("mem_we[%0d]", n), 32'(mem_we_w[n]), 32'(busy && m_we[n]));
        check($sformatf("i_ack[%0d]", n), 32'(i_ack_w[n]), 32'(exp_i));
        check($sformatf("d_ack[%0d]", n), 32'(d_ack_w[n]), 32'(exp_d));
        if (busy) check($sformatf("mem_addr[%0d]", n), mem_addr_w[n], m_addr[n]);
        if (busy && m_we[n]) check($sformatf("mem_wdata[%0d]", n), mem_wdata_w[n], m_wdata[n]);
        if (exp_i) check($sformatf("i_rdata[%0d]", n), i_rdata_w[n], mem_val(m_addr[n]));
        if (exp_d) check($sformatf("d_rdata[%0d]", n), d_rdata_w[n],
                         m_we[n] ? m_dlast[n] : mem_val(m_addr[n]));
      end
    end
  end

  // Wait (bounded) for an ack on instance n; drops that port's request once acked.
  task automatic wait_ack(input int n, input bit port_d, input int maxc,
                          output int lat, output int en_c, output int we_c, output int other_c);
    lat = -1; en_c = 0; we_c = 0; other_c = 0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge Clk);
      if (mem_en_w[n]) en_c++;
      if (mem_we_w[n]) we_c++;
      if (port_d ? i_ack_w[n] : d_ack_w[n]) other_c++;
      if (port_d ? d_ack_w[n] : i_ack_w[n]) begin
        lat = c;
        if (port_d) d_req = 1'b0;
        else        i_req = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int lat, en_c, we_c, oth, il, dl, acks;
    int last_ack [NI];
    int nacks    [NI];

    // Reset state
    repeat (3) @(posedge Clk);
    #3 Clrn = 1'b1;
    @(negedge Clk);
    check("reset_mem_en", 32'(mem_en_w[0]), 32'd0);
    check("reset_i_ack", 32'(i_ack_w[0]), 32'd0);
    check("reset_d_ack", 32'(d_ack_w[0]), 32'd0);
    check("reset_i_rdata", i_rdata_w[0], 32'd0);
    check("reset_d_rdata", d_rdata_w[0], 32'd0);
    check("reset_mem_addr", mem_addr_w[0], 32'd0);

    // Fetch at MEM_LAT=2
    @(posedge Clk); #1 i_req = 1'b1; i_addr = 32'h0000_0040;
    wait_ack(0, 1'b0, 20, lat, en_c, we_c, oth);
    check("fetch_latency", 32'(lat), 32'd3);
    check("fetch_en_cycles", 32'(en_c), 32'd2);
    check("fetch_rdata", i_rdata_w[0], 32'h2002_0005);

    // Store
    @(posedge Clk); #1 d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    wait_ack(0, 1'b1, 20, lat, en_c, we_c, oth);
    d_we = 1'b0;
    check("store_latency", 32'(lat), 32'd3);
    check("store_we_cycles", 32'(we_c), 32'd2);
    check("store_no_i_ack", 32'(oth), 32'd0);
    check("store_wdata", mem_wdata_w[0], 32'hDEAD_BEEF);

    // Conflict
    @(posedge Clk); #1 i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_addr = 32'h20;
    il = -1; dl = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (d_ack_w[0] && dl < 0) begin dl = c; d_req = 1'b0; end
      if (i_ack_w[0] && il < 0) begin il = c; i_req = 1'b0; end
      if (il >= 0 && dl >= 0) break;
    end
`ifdef ARB_RR_EN
    check("conflict_i_first", 32'(il), 32'd3);
    check("conflict_d_second", 32'(dl), 32'(3 + 4));
`else
    check("conflict_d_first", 32'(dl), 32'd3);
    check("conflict_i_second", 32'(il), 32'(3 + 4));
`endif

    // Cancel in the first busy cycle
    @(posedge Clk); #1 i_req = 1'b1; i_addr = 32'h48;
    en_c = 0; acks = 0;
    @(negedge Clk);
    @(posedge Clk); #1 i_cancel = 1'b1;
    @(negedge Clk); en_c += int'(mem_en_w[0]); acks += int'(i_ack_w[0]);
    @(posedge Clk); #1 i_cancel = 1'b0; i_req = 1'b0;
    repeat (6) begin
      @(negedge Clk); en_c += int'(mem_en_w[0]); acks += int'(i_ack_w[0]);
    end
    check("cancel_en_cycles", 32'(en_c), 32'd2);
    check("cancel_no_i_ack", 32'(acks), 32'd0);
    @(posedge Clk); #1 d_req = 1'b1; d_addr = 32'h24;
    wait_ack(0, 1'b1, 20, lat, en_c, we_c, oth);
    check("after_cancel_latency", 32'(lat), 32'd3);
    check("after_cancel_rdata", d_rdata_w[0], 32'h2002_0061);

    // Async reset mid-busy on the MEM_LAT=4 instance
    repeat (40) @(posedge Clk);
    #1 i_req = 1'b1; i_addr = 32'h80;
    @(posedge Clk); @(posedge Clk);
    #1 check("pre_reset_busy", 32'(mem_en_w[1]), 32'd1);
    #1 Clrn = 1'b0;
    #1 check("reset_drops_mem_en", 32'(mem_en_w[1]), 32'd0);
    i_req = 1'b0;
    @(posedge Clk); @(posedge Clk);
    #3 Clrn = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge Clk); acks += int'(i_ack_w[1]) + int'(d_ack_w[1]);
    end
    check("no_ack_after_reset", 32'(acks), 32'd0);
    @(posedge Clk); #1 i_req = 1'b1; i_addr = 32'h84;
    wait_ack(1, 1'b0, 30, lat, en_c, we_c, oth);
    check("post_reset_latency", 32'(lat), 32'd5);
    check("post_reset_rdata", i_rdata_w[1], mem_val(32'h84));

    // Back-to-back fetches on every latency
    repeat (40) @(posedge Clk);
    for (int n = 0; n < NI; n++) begin last_ack[n] = -1; nacks[n] = 0; end
    #1 i_req = 1'b1; i_addr = 32'h100;
    for (int c = 0; c < 100; c++) begin
      @(negedge Clk);
      for (int n = 0; n < NI; n++) begin
        if (i_ack_w[n]) begin
          if (last_ack[n] >= 0)
            check($sformatf("sweep_gap[%0d]", n), 32'(c - last_ack[n]), 32'(lat_of(n) + 2));
          last_ack[n] = c;
          nacks[n]++;
        end
      end
    end
    i_req = 1'b0;
    for (int n = 0; n < NI; n++)
      check($sformatf("sweep_count[%0d]", n), 32'(nacks[n]),
            32'((99 - (lat_of(n) + 1)) / (lat_of(n) + 2) + 1));

    // Random traffic with one asynchronous reset in the middle
    repeat (20) @(posedge Clk);
    for (int c = 0; c < 1500; c++) begin
      @(posedge Clk);
      #1;
      i_req    = ($urandom_range(0, 2) != 0);
      i_cancel = ($urandom_range(0, 7) == 0);
      d_req    = ($urandom_range(0, 2) == 0);
      d_we     = $urandom_range(0, 1) == 1;
      i_addr   = $urandom;
      d_addr   = $urandom;
      d_wdata  = $urandom;
      if (c == 700) begin
        #1 Clrn = 1'b0;
        @(posedge Clk); @(posedge Clk);
        #3 Clrn = 1'b1;
      end
    end
    #1 i_req = 1'b0; d_req = 1'b0; i_cancel = 1'b0;
    repeat (40) @(posedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
